// File: rtl/plastic_neuron_array.sv
// Multi-synapse plastic neuron: time-multiplexed MAC over N_SYN synapses with a
// saturating sign-Hebbian weight update. Define PLASTIC_DECAY_EN for weight decay.
module plastic_neuron_array #(
  parameter int N_SYN  = 4,
  parameter int DW     = 16,
  parameter int WW     = 16,
  parameter int ACC_W  = 40,
  parameter int LR     = 23,
  parameter int W_INIT = 1070,
  localparam int SELW  = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_SYN*DW-1:0]     in_data,
  input  logic signed [DW-1:0]    err,
  input  logic                    learn_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  input  logic [SELW-1:0]         w_sel,
  output logic signed [WW-1:0]    w_rd,
  output logic                    busy
);

  localparam int PW = DW + WW;
  localparam logic signed [WW+1:0] LR_EXT    = (WW+2)'(LR);
  localparam logic signed [WW+1:0] W_MAX_EXT = {3'b000, {(WW-1){1'b1}}};
  localparam logic signed [WW+1:0] W_MIN_EXT = {3'b111, {(WW-1){1'b0}}};
  localparam logic signed [WW-1:0] W_MAX     = {1'b0, {(WW-1){1'b1}}};
  localparam logic signed [WW-1:0] W_MIN     = {1'b1, {(WW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, OUT, LEARN} state_t;

  state_t                  state;
  logic [SELW-1:0]         idx;
  logic signed [DW-1:0]    x_q [N_SYN];
  logic signed [DW-1:0]    err_q;
  logic                    learn_q;
  logic signed [WW-1:0]    w [N_SYN];
  logic signed [ACC_W-1:0] acc;

  logic                    last;
  logic signed [DW-1:0]    x_cur;
  logic signed [WW-1:0]    w_cur;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_next;
  logic                    x_pos;
  logic                    err_pos;
  logic                    err_neg;
  logic signed [WW+1:0]    w_step;
  logic signed [WW-1:0]    w_new;

  assign last     = (idx == SELW'(N_SYN - 1));
  assign x_cur    = x_q[idx];
  assign w_cur    = w[idx];
  assign prod     = PW'(x_cur) * PW'(w_cur);
  assign acc_next = acc + ACC_W'(prod);
  assign x_pos    = !x_cur[DW-1] && (x_cur != '0);
  assign err_pos  = !err_q[DW-1] && (err_q != '0);
  assign err_neg  = err_q[DW-1];

  // Step is computed two bits wider than the weight so the clamp sees the true sum.
  always_comb begin
    w_step = (WW+2)'(w_cur);
    if (x_pos && err_pos)
      w_step = (WW+2)'(w_cur) + LR_EXT;
    else if (x_pos && err_neg)
      w_step = (WW+2)'(w_cur) - LR_EXT;

    if (w_step > W_MAX_EXT)
      w_new = W_MAX;
    else if (w_step < W_MIN_EXT)
      w_new = W_MIN;
    else
      w_new = w_step[WW-1:0];

`ifdef PLASTIC_DECAY_EN
    if (!(x_pos && (err_pos || err_neg))) begin
      if (!w_cur[WW-1] && (w_cur != '0))
        w_new = w_cur - WW'(1);
      else if (w_cur[WW-1])
        w_new = w_cur + WW'(1);
      else
        w_new = w_cur;
    end
`endif
  end

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < N_SYN; k++)
      if (w_sel == SELW'(k))
        w_rd = w[k];
  end

  // Single sequencer: handshake flags are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      err_q     <= '0;
      learn_q   <= 1'b0;
      for (int k = 0; k < N_SYN; k++) begin
        w[k]   <= WW'(W_INIT);
        x_q[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < N_SYN; k++)
              x_q[k] <= in_data[k*DW +: DW];
            err_q    <= err;
            learn_q  <= learn_en;
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (last) begin
            out_data  <= acc_next;
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= OUT;
          end else begin
            idx <= idx + SELW'(1);
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (learn_q) begin
              state <= LEARN;
            end else begin
              in_ready <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        LEARN: begin
          w[idx] <= w_new;
          if (last) begin
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            idx <= idx + SELW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plastic_neuron_array.sv
// Directed bench for plastic_neuron_array: inference, learning, saturation,
// backpressure and asynchronous reset. Honours PLASTIC_DECAY_EN for expectations.
module tb_plastic_neuron_array;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               in_valid, in_ready, learn_en, out_valid, out_ready, busy;
  logic [63:0]        in_data;
  logic signed [15:0] err, w_rd;
  logic signed [39:0] out_data;
  logic [1:0]         w_sel;

  logic               s_in_valid, s_learn, s_out_ready;
  logic [63:0]        s_in_data;
  logic [1:0]         s_w_sel;
  logic signed [15:0] err_hi, err_lo, hi_w_rd, lo_w_rd;
  logic               hi_in_ready, hi_out_valid, hi_busy, lo_in_ready, lo_out_valid, lo_busy;
  logic signed [39:0] hi_out_data, lo_out_data;

  plastic_neuron_array u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .err(err), .learn_en(learn_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .w_sel(w_sel), .w_rd(w_rd), .busy(busy)
  );

  plastic_neuron_array #(.W_INIT(32760)) u_hi (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(hi_in_ready), .in_data(s_in_data),
    .err(err_hi), .learn_en(s_learn), .out_valid(hi_out_valid), .out_ready(s_out_ready),
    .out_data(hi_out_data), .w_sel(s_w_sel), .w_rd(hi_w_rd), .busy(hi_busy)
  );

  plastic_neuron_array #(.W_INIT(-32760)) u_lo (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(lo_in_ready), .in_data(s_in_data),
    .err(err_lo), .learn_en(s_learn), .out_valid(lo_out_valid), .out_ready(s_out_ready),
    .out_data(lo_out_data), .w_sel(s_w_sel), .w_rd(lo_w_rd), .busy(lo_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] packX(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic checkWeights(input string tag, input int e0, input int e1, input int e2, input int e3);
    int expw [4];
    expw = '{e0, e1, e2, e3};
    for (int k = 0; k < 4; k++) begin
      w_sel = 2'(k);
      #1;
      checkOutput($sformatf("%s_w%0d", tag, k), w_rd, expw[k]);
    end
  endtask

  // Offers one vector and waits for out_valid; lat counts edges from the accept edge.
  task automatic applyStimulus(input logic [63:0] data, input int e, input logic learn,
                               output int lat, output longint result);
    in_data  = data;
    err      = e[15:0];
    learn_en = learn;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) checkOutput("out_valid_timeout", 0, 1);
    result = out_data;
  endtask

  task automatic completeOutput(input logic learn);
    int n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (learn) begin
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready) checkOutput("learn_timeout", 0, 1);
    end
  endtask

  initial begin
    int     lat, n;
    longint res;

    rst = 1'b1; in_valid = 0; in_data = '0; err = '0; learn_en = 0; out_ready = 0; w_sel = '0;
    s_in_valid = 0; s_learn = 0; s_out_ready = 0; s_in_data = '0; s_w_sel = '0; err_hi = '0; err_lo = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkWeights("rst", 1070, 1070, 1070, 1070);

    applyStimulus(packX(1, 2, 3, 4), 0, 1'b0, lat, res);
    checkOutput("infer_latency", lat, 5);
    checkOutput("infer_sum", res, 10700);
    checkOutput("infer_busy", busy, 1);
    completeOutput(1'b0);
    checkOutput("infer_in_ready", in_ready, 1);
    checkOutput("infer_out_valid_fall", out_valid, 0);
    checkWeights("infer", 1070, 1070, 1070, 1070);

    applyStimulus(packX(1, -1, 0, 2), 5, 1'b1, lat, res);
    checkOutput("learn_sum", res, 2140);
    completeOutput(1'b1);
`ifdef PLASTIC_DECAY_EN
    checkWeights("learn", 1093, 1069, 1069, 1093);
`else
    checkWeights("learn", 1093, 1070, 1070, 1093);
`endif

    applyStimulus(packX(1, 1, 1, 1), 0, 1'b1, lat, res);
`ifdef PLASTIC_DECAY_EN
    checkOutput("err0_sum", res, 4324);
    completeOutput(1'b1);
    checkWeights("err0", 1092, 1068, 1068, 1092);
`else
    checkOutput("err0_sum", res, 4326);
    completeOutput(1'b1);
    checkWeights("err0", 1093, 1070, 1070, 1093);
`endif

    applyStimulus(packX(2, 0, 0, 0), -5, 1'b1, lat, res);
`ifdef PLASTIC_DECAY_EN
    checkOutput("errneg_sum", res, 2184);
    completeOutput(1'b1);
    checkWeights("errneg", 1069, 1067, 1067, 1091);
`else
    checkOutput("errneg_sum", res, 2186);
    completeOutput(1'b1);
    checkWeights("errneg", 1070, 1070, 1070, 1093);
`endif

    applyStimulus(packX(-3, 0, 0, 1), 0, 1'b0, lat, res);
`ifdef PLASTIC_DECAY_EN
    checkOutput("bp_sum", res, -2116);
`else
    checkOutput("bp_sum", res, -2117);
`endif
    in_data  = packX(7, 7, 7, 7);
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
`ifdef PLASTIC_DECAY_EN
      checkOutput($sformatf("bp_hold_data%0d", c), out_data, -2116);
`else
      checkOutput($sformatf("bp_hold_data%0d", c), out_data, -2117);
`endif
      checkOutput($sformatf("bp_hold_valid%0d", c), out_valid, 1);
      checkOutput($sformatf("bp_hold_ready%0d", c), in_ready, 0);
    end
    in_valid = 1'b0;
    completeOutput(1'b0);
    checkOutput("bp_done_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("bp_no_extra_txn", busy, 0);

    in_data = packX(1, 1, 1, 1); err = 16'sd5; learn_en = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rstmac_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    checkOutput("rstmac_busy", busy, 0);
    checkOutput("rstmac_in_ready", in_ready, 1);
    checkOutput("rstmac_out_valid", out_valid, 0);
    checkOutput("rstmac_out_data", out_data, 0);
    checkWeights("rstmac", 1070, 1070, 1070, 1070);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(packX(1, 1, 1, 1), 5, 1'b1, lat, res);
    checkOutput("rstlearn_sum", res, 4280);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    w_sel = 2'd0;
    #1;
    checkOutput("rstlearn_w0_mid", w_rd, 1093);
    rst = 1'b1;
    #1;
    checkOutput("rstlearn_busy", busy, 0);
    checkOutput("rstlearn_in_ready", in_ready, 1);
    checkWeights("rstlearn", 1070, 1070, 1070, 1070);
    rst = 1'b0;
    @(posedge clk); #1;

    s_in_data = packX(1, 1, 1, 1); s_learn = 1'b1; err_hi = 16'sd1; err_lo = -16'sd1;
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    n = 0;
    while (!hi_out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("sat_out_valid", hi_out_valid, 1);
    checkOutput("sat_hi_sum", hi_out_data, 131040);
    checkOutput("sat_lo_sum", lo_out_data, -131040);
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    n = 0;
    while (!hi_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("sat_done", hi_in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      s_w_sel = 2'(k);
      #1;
      checkOutput($sformatf("sat_hi_w%0d", k), hi_w_rd, 32767);
      checkOutput($sformatf("sat_lo_w%0d", k), lo_w_rd, -32768);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
